stat_display_sched: RTL and testbench

STAT_DISPLAY_SCHED -- requirements
Module: stat_display_sched

---
 rtl/stat_disp_pkg.sv | 36 +++
 rtl/dwell_timer.sv | 32 +++
 rtl/stat_display_sched.sv | 191 +++++++++++++++++++
 tb/tb_stat_display_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stat_disp_pkg.sv
// Shared types and codes for the statistics display scheduler.
// State enum, op/source codes, dwell default and rotate-step helper.
package stat_disp_pkg;

  typedef enum logic [1:0] {
    ST_FIXED,
    ST_SCAN,
    ST_ROTATE
  } state_t;

  localparam logic [2:0] OP_CPU    = 3'd0;
  localparam logic [2:0] OP_CYCLES = 3'd1;
  localparam logic [2:0] OP_UNCOND = 3'd2;
  localparam logic [2:0] OP_COND   = 3'd3;
  localparam logic [2:0] OP_BUBBLE = 3'd4;
  localparam logic [2:0] OP_SCAN   = 3'd5;
  localparam logic [2:0] OP_ROTATE = 3'd6;
  localparam logic [2:0] OP_ALIAS  = 3'd7;

  localparam logic [2:0] SRC_CPU    = 3'd0;
  localparam logic [2:0] SRC_CYCLES = 3'd1;
  localparam logic [2:0] SRC_UNCOND = 3'd2;
  localparam logic [2:0] SRC_COND   = 3'd3;
  localparam logic [2:0] SRC_BUBBLE = 3'd4;
  localparam logic [2:0] SRC_RAM    = 3'd5;

  localparam int DWELL_DEFAULT = 50000000;

  function automatic logic [2:0] rot_next(
    input logic [2:0] s
  );
    return (s == SRC_BUBBLE) ? SRC_CYCLES
                             : s + 3'd1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter with synchronous clear.
// Ports: clk, rst (async active-low), clr, tc (terminal-count pulse).
module dwell_timer
  import stat_disp_pkg::*;
#(
  parameter int CYCLES = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam int W = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  // a clear in the same cycle masks the expiry
  assign tc = !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/stat_display_sched.sv
// Chooses what the 7-segment display shows: CPU value, a stat counter,
// a RAM scan or a rotation over the counters. Optional STAT_SNAPSHOT_EN
// latches all four counters together so rotated values are consistent.
// Ports: clk, rst (async active-low), display_op, led_cpu_enable,
//   led_data_in, total_cycles, uncondi_branch_num, condi_branch_num,
//   bubble_num, ram_display_data_out -> ram_display_addr, disp_data,
//   disp_src, disp_update.
module stat_display_sched
  import stat_disp_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int DWELL_CYCLES = DWELL_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           display_op,
  input  logic                 led_cpu_enable,
  input  logic [31:0]          led_data_in,
  input  logic [31:0]          total_cycles,
  input  logic [31:0]          uncondi_branch_num,
  input  logic [31:0]          condi_branch_num,
  input  logic [31:0]          bubble_num,
  input  logic [31:0]          ram_display_data_out,
  output logic [ADDR_BITS-3:0] ram_display_addr,
  output logic [31:0]          disp_data,
  output logic [2:0]           disp_src,
  output logic                 disp_update
);

  localparam int AW = ADDR_BITS - 2;

  state_t        state_q, n_state;
  logic [2:0]    op_q, n_src;
  logic [AW-1:0] n_addr;
  logic [31:0]   n_data, n_hold, cpu_hold;
  logic          n_upd, n_cap, cap_q, live_q;
  logic          state_chg, step;
  logic [31:0]   st_c, st_u, st_k, st_b;

  function automatic logic [31:0] pick(
    input logic [2:0]  s,
    input logic [31:0] c,
    input logic [31:0] u,
    input logic [31:0] k,
    input logic [31:0] b
  );
    case (s)
      SRC_UNCOND: pick = u;
      SRC_COND:   pick = k;
      SRC_BUBBLE: pick = b;
      default:    pick = c;
    endcase
  endfunction

  // step is never raised in a state-change cycle, so op changes win
  dwell_timer #(
    .CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk(clk),
    .rst(rst),
    .clr(state_chg),
    .tc (step)
  );

`ifdef STAT_SNAPSHOT_EN
  logic [31:0] snap_c, snap_u, snap_k, snap_b;
  logic        stat_now, stat_next, snap_ld;

  assign stat_now  = disp_src != SRC_CPU
                  && disp_src != SRC_RAM;
  assign stat_next = n_state == ST_ROTATE
                  || (n_state == ST_FIXED
                      && op_q != OP_CPU);
  assign snap_ld   = stat_next
                  && (state_chg || !stat_now || step);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_c <= '0;
      snap_u <= '0;
      snap_k <= '0;
      snap_b <= '0;
    end else if (snap_ld) begin
      snap_c <= total_cycles;
      snap_u <= uncondi_branch_num;
      snap_k <= condi_branch_num;
      snap_b <= bubble_num;
    end
  end

  // on a latch cycle the shown value is the one being captured
  assign st_c = snap_ld ? total_cycles       : snap_c;
  assign st_u = snap_ld ? uncondi_branch_num : snap_u;
  assign st_k = snap_ld ? condi_branch_num   : snap_k;
  assign st_b = snap_ld ? bubble_num         : snap_b;
`else
  assign st_c = total_cycles;
  assign st_u = uncondi_branch_num;
  assign st_k = condi_branch_num;
  assign st_b = bubble_num;
`endif

  always_comb begin
    n_state = ST_FIXED;
    unique case (1'b1)
      op_q == OP_SCAN:   n_state = ST_SCAN;
      op_q == OP_ROTATE: n_state = ST_ROTATE;
      default:           n_state = ST_FIXED;
    endcase
  end

  assign state_chg = n_state != state_q;

  always_comb begin
    n_addr = ram_display_addr;
    n_data = disp_data;
    n_src  = disp_src;
    n_upd  = !live_q;
    n_cap  = 1'b0;
    n_hold = led_cpu_enable ? led_data_in : cpu_hold;
    case (n_state)
      ST_FIXED: begin
        n_src = op_q;
        if (op_q == OP_CPU) begin
          if (led_cpu_enable) begin
            n_data = led_data_in;
            n_upd  = 1'b1;
          end else if (state_chg
                       || disp_src != SRC_CPU) begin
            n_data = cpu_hold;
          end
        end else begin
          n_data = pick(op_q, st_c, st_u, st_k, st_b);
        end
      end
      ST_SCAN: begin
        n_src = SRC_RAM;
        if (state_chg) begin
          n_data = ram_display_data_out;
        end else if (cap_q) begin
          n_data = ram_display_data_out;
          n_upd  = 1'b1;
        end
        // RAM read is combinational on the address, so the
        // new word is captured on the following edge
        if (step) begin
          n_addr = ram_display_addr + AW'(1);
          n_cap  = 1'b1;
        end
      end
      ST_ROTATE: begin
        if (state_chg) begin
          n_src = SRC_CYCLES;
        end else if (step) begin
          n_src = rot_next(disp_src);
        end
        n_data = pick(n_src, st_c, st_u, st_k, st_b);
      end
      default: ;
    endcase
    if (state_chg || n_src != disp_src) begin
      n_upd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q             <= OP_CPU;
      state_q          <= ST_FIXED;
      ram_display_addr <= '0;
      disp_data        <= '0;
      disp_src         <= SRC_CPU;
      disp_update      <= 1'b0;
      cpu_hold         <= '0;
      cap_q            <= 1'b0;
      live_q           <= 1'b0;
    end else begin
      op_q             <= (display_op == OP_ALIAS)
                          ? OP_CPU : display_op;
      state_q          <= n_state;
      ram_display_addr <= n_addr;
      disp_data        <= n_data;
      disp_src         <= n_src;
      disp_update      <= n_upd;
      cpu_hold         <= n_hold;
      cap_q            <= n_cap;
      live_q           <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stat_display_sched.sv
// Directed bench for stat_display_sched with DWELL_CYCLES=4.
// A second instance with ADDR_BITS=4 covers the scan wrap.
module tb_stat_display_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  display_op = 3'd0;
  logic        led_cpu_enable = 1'b0;
  logic [31:0] led_data_in = '0;
  logic [31:0] total_cycles = '0;
  logic [31:0] uncondi_branch_num = '0;
  logic [31:0] condi_branch_num = '0;
  logic [31:0] bubble_num = '0;
  logic [31:0] ram_q, ram_w;
  logic [9:0]  addr;
  logic [1:0]  addr_w;
  logic [31:0] disp_data, data_w;
  logic [2:0]  disp_src, src_w;
  logic        disp_update, upd_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // RAM word k holds k*16
  assign ram_q = {18'd0, addr, 4'd0};
  assign ram_w = {26'd0, addr_w, 4'd0};

  stat_display_sched #(
    .ADDR_BITS(12),
    .DWELL_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .display_op(display_op),
    .led_cpu_enable(led_cpu_enable),
    .led_data_in(led_data_in),
    .total_cycles(total_cycles),
    .uncondi_branch_num(uncondi_branch_num),
    .condi_branch_num(condi_branch_num),
    .bubble_num(bubble_num),
    .ram_display_data_out(ram_q),
    .ram_display_addr(addr),
    .disp_data(disp_data),
    .disp_src(disp_src),
    .disp_update(disp_update)
  );

  stat_display_sched #(
    .ADDR_BITS(4),
    .DWELL_CYCLES(4)
  ) dut_w (
    .clk(clk),
    .rst(rst),
    .display_op(display_op),
    .led_cpu_enable(led_cpu_enable),
    .led_data_in(led_data_in),
    .total_cycles(total_cycles),
    .uncondi_branch_num(uncondi_branch_num),
    .condi_branch_num(condi_branch_num),
    .bubble_num(bubble_num),
    .ram_display_data_out(ram_w),
    .ram_display_addr(addr_w),
    .disp_data(data_w),
    .disp_src(src_w),
    .disp_update(upd_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    display_op = 3'd0;
    repeat (2) tick();
    n_cmp++; if (disp_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want %h", disp_data, 32'h0); end
    n_cmp++; if (disp_src !== 3'd0) begin n_bad++; $display("FAIL rst_src got %0d want 0", disp_src); end
    n_cmp++; if (disp_update !== 1'b0) begin n_bad++; $display("FAIL rst_upd got %b want 0", disp_update); end
    n_cmp++; if (addr !== 10'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", addr); end
    rst = 1'b1;
    tick();
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL rel_upd got %b want 1", disp_update); end
    n_cmp++; if (disp_data !== 32'h0) begin n_bad++; $display("FAIL rel_data got %h want %h", disp_data, 32'h0); end
    n_cmp++; if (disp_src !== 3'd0) begin n_bad++; $display("FAIL rel_src got %0d want 0", disp_src); end
    tick();
    n_cmp++; if (disp_update !== 1'b0) begin n_bad++; $display("FAIL rel_upd2 got %b want 0", disp_update); end
  endtask

  task automatic test_cpu_load();
    led_cpu_enable = 1'b1;
    led_data_in = 32'h1234ABCD;
    tick();
    led_cpu_enable = 1'b0;
    led_data_in = 32'h0;
    n_cmp++; if (disp_data !== 32'h1234ABCD) begin n_bad++; $display("FAIL cpu_load got %h want %h", disp_data, 32'h1234ABCD); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL cpu_upd got %b want 1", disp_update); end
    tick();
    n_cmp++; if (disp_data !== 32'h1234ABCD) begin n_bad++; $display("FAIL cpu_hold1 got %h want %h", disp_data, 32'h1234ABCD); end
    n_cmp++; if (disp_update !== 1'b0) begin n_bad++; $display("FAIL cpu_upd2 got %b want 0", disp_update); end
    tick();
    n_cmp++; if (disp_data !== 32'h1234ABCD) begin n_bad++; $display("FAIL cpu_hold2 got %h want %h", disp_data, 32'h1234ABCD); end
  endtask

  task automatic test_scan();
    display_op = 3'd5;
    tick();
    n_cmp++; if (disp_src !== 3'd0) begin n_bad++; $display("FAIL op_lat got %0d want 0", disp_src); end
    tick();
    n_cmp++; if (disp_src !== 3'd5) begin n_bad++; $display("FAIL scan_src got %0d want 5", disp_src); end
    n_cmp++; if (disp_data !== 32'd0) begin n_bad++; $display("FAIL scan_d0 got %0d want 0", disp_data); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL scan_upd got %b want 1", disp_update); end
    n_cmp++; if (src_w !== 3'd5 || upd_w !== 1'b1) begin n_bad++; $display("FAIL scanw_ent got %0d/%b want 5/1", src_w, upd_w); end
    repeat (3) tick();
    n_cmp++; if (addr !== 10'd0) begin n_bad++; $display("FAIL scan_a0 got %0d want 0", addr); end
    tick();
    n_cmp++; if (addr !== 10'd1) begin n_bad++; $display("FAIL scan_a1 got %0d want 1", addr); end
    n_cmp++; if (disp_data !== 32'd0) begin n_bad++; $display("FAIL scan_pre got %0d want 0", disp_data); end
    tick();
    n_cmp++; if (disp_data !== 32'd16) begin n_bad++; $display("FAIL scan_d1 got %0d want 16", disp_data); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL scan_cap got %b want 1", disp_update); end
    repeat (3) tick();
    n_cmp++; if (addr !== 10'd2) begin n_bad++; $display("FAIL scan_a2 got %0d want 2", addr); end
    tick();
    n_cmp++; if (disp_data !== 32'd32) begin n_bad++; $display("FAIL scan_d2 got %0d want 32", disp_data); end
    repeat (3) tick();
    n_cmp++; if (addr_w !== 2'd3) begin n_bad++; $display("FAIL wrap_a3 got %0d want 3", addr_w); end
    repeat (4) tick();
    n_cmp++; if (addr_w !== 2'd0) begin n_bad++; $display("FAIL wrap_a0 got %0d want 0", addr_w); end
    n_cmp++; if (addr !== 10'd4) begin n_bad++; $display("FAIL scan_a4 got %0d want 4", addr); end
    tick();
    n_cmp++; if (data_w !== 32'd0) begin n_bad++; $display("FAIL wrap_d0 got %0d want 0", data_w); end
  endtask

  task automatic test_scan_reset();
    for (int i = 0; i < 40 && addr !== 10'd5; i++) tick();
    n_cmp++; if (addr !== 10'd5) begin n_bad++; $display("FAIL reach_a5 got %0d want 5", addr); end
    rst = 1'b0;
    #1;
    n_cmp++; if (addr !== 10'd0) begin n_bad++; $display("FAIL async_addr got %0d want 0", addr); end
    n_cmp++; if (disp_data !== 32'd0) begin n_bad++; $display("FAIL async_data got %0d want 0", disp_data); end
    n_cmp++; if (disp_src !== 3'd0) begin n_bad++; $display("FAIL async_src got %0d want 0", disp_src); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL rel2_upd got %b want 1", disp_update); end
    tick();
    n_cmp++; if (disp_src !== 3'd5 || addr !== 10'd0) begin n_bad++; $display("FAIL rescan got %0d/%0d want 5/0", disp_src, addr); end
    repeat (3) tick();
    n_cmp++; if (addr !== 10'd0) begin n_bad++; $display("FAIL rescan_a0 got %0d want 0", addr); end
    tick();
    n_cmp++; if (addr !== 10'd1) begin n_bad++; $display("FAIL rescan_a1 got %0d want 1", addr); end
  endtask

  task automatic test_rotate();
    total_cycles = 32'd100;
    uncondi_branch_num = 32'd7;
    condi_branch_num = 32'd9;
    bubble_num = 32'd3;
    display_op = 3'd6;
    repeat (2) tick();
    n_cmp++; if (disp_src !== 3'd1 || disp_data !== 32'd100) begin n_bad++; $display("FAIL rot_1 got %0d/%0d want 1/100", disp_src, disp_data); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL rot_upd got %b want 1", disp_update); end
    tick();
    n_cmp++; if (disp_update !== 1'b0) begin n_bad++; $display("FAIL rot_upd0 got %b want 0", disp_update); end
    repeat (2) tick();
    n_cmp++; if (disp_src !== 3'd1) begin n_bad++; $display("FAIL rot_dw got %0d want 1", disp_src); end
    tick();
    n_cmp++; if (disp_src !== 3'd2 || disp_data !== 32'd7) begin n_bad++; $display("FAIL rot_2 got %0d/%0d want 2/7", disp_src, disp_data); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL rot_upd2 got %b want 1", disp_update); end
    repeat (4) tick();
    n_cmp++; if (disp_src !== 3'd3 || disp_data !== 32'd9) begin n_bad++; $display("FAIL rot_3 got %0d/%0d want 3/9", disp_src, disp_data); end
    repeat (4) tick();
    n_cmp++; if (disp_src !== 3'd4 || disp_data !== 32'd3) begin n_bad++; $display("FAIL rot_4 got %0d/%0d want 4/3", disp_src, disp_data); end
    repeat (4) tick();
    n_cmp++; if (disp_src !== 3'd1 || disp_data !== 32'd100) begin n_bad++; $display("FAIL rot_wrap got %0d/%0d want 1/100", disp_src, disp_data); end
    total_cycles = 32'd150;
    tick();
`ifdef STAT_SNAPSHOT_EN
    n_cmp++; if (disp_data !== 32'd100) begin n_bad++; $display("FAIL rot_snap got %0d want 100", disp_data); end
`else
    n_cmp++; if (disp_data !== 32'd150) begin n_bad++; $display("FAIL rot_live got %0d want 150", disp_data); end
`endif
  endtask

  task automatic test_cpu_hold();
    led_cpu_enable = 1'b1;
    led_data_in = 32'hDEAD;
    tick();
    led_cpu_enable = 1'b0;
    led_data_in = 32'h0;
    n_cmp++; if (disp_src !== 3'd1) begin n_bad++; $display("FAIL hold_src got %0d want 1", disp_src); end
`ifdef STAT_SNAPSHOT_EN
    n_cmp++; if (disp_data !== 32'd100) begin n_bad++; $display("FAIL hold_rot got %0d want 100", disp_data); end
`else
    n_cmp++; if (disp_data !== 32'd150) begin n_bad++; $display("FAIL hold_rot got %0d want 150", disp_data); end
`endif
    display_op = 3'd0;
    repeat (2) tick();
    n_cmp++; if (disp_data !== 32'hDEAD) begin n_bad++; $display("FAIL hold_show got %h want %h", disp_data, 32'hDEAD); end
    n_cmp++; if (disp_src !== 3'd0) begin n_bad++; $display("FAIL hold_src0 got %0d want 0", disp_src); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL hold_upd got %b want 1", disp_update); end
  endtask

  task automatic test_op_race();
    display_op = 3'd5;
    repeat (2) tick();
    n_cmp++; if (addr !== 10'd1 || disp_data !== 32'd16) begin n_bad++; $display("FAIL keep_addr got %0d/%0d want 1/16", addr, disp_data); end
    repeat (2) tick();
    display_op = 3'd0;
    repeat (2) tick();
    n_cmp++; if (addr !== 10'd1) begin n_bad++; $display("FAIL race_addr got %0d want 1", addr); end
    n_cmp++; if (disp_src !== 3'd0 || disp_data !== 32'hDEAD) begin n_bad++; $display("FAIL race_out got %0d/%h want 0/dead", disp_src, disp_data); end
  endtask

  task automatic test_fixed_stat();
    condi_branch_num = 32'd9;
    display_op = 3'd3;
    repeat (2) tick();
    n_cmp++; if (disp_src !== 3'd3 || disp_data !== 32'd9) begin n_bad++; $display("FAIL fix_3 got %0d/%0d want 3/9", disp_src, disp_data); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL fix_upd got %b want 1", disp_update); end
    condi_branch_num = 32'd11;
    tick();
`ifdef STAT_SNAPSHOT_EN
    n_cmp++; if (disp_data !== 32'd9) begin n_bad++; $display("FAIL fix_snap got %0d want 9", disp_data); end
`else
    n_cmp++; if (disp_data !== 32'd11) begin n_bad++; $display("FAIL fix_live got %0d want 11", disp_data); end
`endif
    display_op = 3'd7;
    repeat (2) tick();
    n_cmp++; if (disp_src !== 3'd0 || disp_data !== 32'hDEAD) begin n_bad++; $display("FAIL op7 got %0d/%h want 0/dead", disp_src, disp_data); end
    n_cmp++; if (disp_update !== 1'b1) begin n_bad++; $display("FAIL op7_upd got %b want 1", disp_update); end
  endtask

  initial begin
    test_reset();
    test_cpu_load();
    test_scan();
    test_scan_reset();
    test_rotate();
    test_cpu_hold();
    test_op_race();
    test_fixed_stat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
